// File: rtl/sm_regfile_dump.sv
// Shares the schoolRISCV debug read port between the switch-driven hex display and a
// button-started dump engine that streams every register MSB-first over valid/ready.
module sm_regfile_dump #(
    parameter int unsigned REG_COUNT = 32,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  manualAddr,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [31:0] dispData,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, HDR, LATCH, SEND} state_t;

    localparam logic [4:0] LAST_IDX = 5'(REG_COUNT - 1);

    state_t      state;
    logic [4:0]  idx;
    logic [1:0]  byte_cnt;
    logic [31:0] shift;
    logic        start_prev;
    logic        start_edge;

    assign start_edge = start & ~start_prev;

    always_ff @(posedge clkIn) begin
        // A button level held through reset must not look like a fresh press afterwards,
        // so the previous-level register keeps sampling even while reset is asserted.
        start_prev <= start;
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // in this block sees the pre-edge values, independent of statement order.
            state    <= IDLE;
            regAddr  <= '0;
            dispData <= '0;
            outData  <= '0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            idx      <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= HDR;
                        outData  <= HDR_BYTE;
                        outValid <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        regAddr  <= manualAddr;
                        dispData <= regData;
                    end
                end
                HDR: begin
                    if (outReady) begin
                        regAddr  <= '0;
                        idx      <= '0;
                        outValid <= 1'b0;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    // regAddr already points at idx, so regData is this register's value.
                    shift    <= regData;
                    byte_cnt <= '0;
                    outData  <= regData[31:24];
                    outValid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (outReady) begin
                        if (byte_cnt != 2'd3) begin
                            shift    <= shift << 8;
                            outData  <= shift[23:16];
                            byte_cnt <= byte_cnt + 2'd1;
                        end else if (idx != LAST_IDX) begin
                            idx      <= idx + 5'd1;
                            regAddr  <= idx + 5'd1;
                            outValid <= 1'b0;
                            state    <= LATCH;
                        end else begin
                            outValid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_regfile_dump.sv
// Self-checking bench for sm_regfile_dump: a register-file model drives regData and the
// expected byte stream is computed from the register contents with plain arithmetic.
module tb_sm_regfile_dump;

    localparam int N         = 32;
    localparam int FRAME     = 1 + 4 * N;
    localparam int DUMP_CYCS = 1 + 5 * N;

    logic        clkIn = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  manualAddr;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [31:0] dispData;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic        busy;

    logic [31:0] regs [N];
    int checks = 0;
    int errors = 0;

    always #5 clkIn = ~clkIn;

    assign regData = regs[regAddr];

    sm_regfile_dump #(.REG_COUNT(N), .HDR_BYTE(8'hA5)) dut (
        .clkIn      (clkIn),
        .rst_n      (rst_n),
        .start      (start),
        .manualAddr (manualAddr),
        .regAddr    (regAddr),
        .regData    (regData),
        .dispData   (dispData),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // Byte k of a frame: 0 is the header, then each register MSB first.
    function automatic logic [7:0] exp_byte(input int k);
        int r;
        int b;
        if (k == 0) return 8'hA5;
        r = (k - 1) / 4;
        b = (k - 1) % 4;
        return 8'(regs[r] >> (8 * (3 - b)));
    endfunction

    // Starts a dump and follows it to completion (or to stop_after transferred bytes).
    task automatic run_dump(input string tag, input int ready_pct, input bit pulses,
                            input int stop_after, output int busy_cycles, output int got_n);
        logic [7:0]  got [$];
        logic [31:0] disp_ref;
        logic [7:0]  pd;
        bit          pv;
        bit          pr;
        int          low_valid;
        disp_ref    = regs[manualAddr];
        low_valid   = 0;
        busy_cycles = 0;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        start    = 1'b1;
        outReady = ($urandom_range(0, 99) < ready_pct);
        tick();
        start = 1'b0;
        check({tag, " start valid"}, outValid, 1);
        check({tag, " start hdr"}, outData, 8'hA5);
        check({tag, " start busy"}, busy, 1);
        for (int cyc = 0; cyc < 4000 && busy; cyc++) begin
            busy_cycles++;
            check({tag, " disp frozen"}, dispData, disp_ref);
            if (pv && !pr) begin
                check({tag, " hold valid"}, outValid, 1);
                check({tag, " hold data"}, outData, pd);
            end
            if (!outValid) low_valid++;
            if (pulses) begin
                if (busy_cycles == DUMP_CYCS)        start = 1'b1;
                else if (busy_cycles < DUMP_CYCS - 2) start = 1'($urandom_range(0, 1));
                else                                  start = 1'b0;
            end
            outReady = ($urandom_range(0, 99) < ready_pct);
            if (outValid && outReady) got.push_back(outData);
            pv = outValid;
            pr = outReady;
            pd = outData;
            tick();
            if (stop_after > 0 && got.size() >= stop_after) break;
        end
        got_n = got.size();
        for (int i = 0; i < got.size() && i < FRAME; i++)
            check($sformatf("%s byte %0d", tag, i), got[i], exp_byte(i));
        if (stop_after == 0) begin
            check({tag, " ended"}, busy, 0);
            check({tag, " valid after end"}, outValid, 0);
            check({tag, " frame length"}, got_n, FRAME);
            if (ready_pct == 100) check({tag, " valid low cycles"}, low_valid, N);
        end
    endtask

    initial begin
        int bc;
        int gn;
        int a;
        for (int i = 0; i < N; i++) regs[i] = 32'(i) * 32'h01010101;
        rst_n      = 1'b0;
        start      = 1'b1;
        outReady   = 1'b0;
        manualAddr = '0;
        tick();
        tick();
        check("rst regAddr", regAddr, 0);
        check("rst dispData", dispData, 0);
        check("rst outData", outData, 0);
        check("rst outValid", outValid, 0);
        check("rst busy", busy, 0);

        // start still high at release: no edge, no dump
        rst_n = 1'b1;
        repeat (5) tick();
        check("held start busy", busy, 0);
        check("held start valid", outValid, 0);
        start = 1'b0;
        tick();

        manualAddr = 5'd5;
        tick();
        check("manual regAddr", regAddr, 5);
        check("manual disp old", dispData, 0);
        tick();
        check("manual dispData", dispData, 32'h05050505);
        repeat (4) begin
            a = $urandom_range(0, N - 1);
            manualAddr = 5'(a);
            tick();
            tick();
            check("rand manual regAddr", regAddr, a);
            check("rand manual dispData", dispData, regs[a]);
        end

        manualAddr = 5'd7;
        tick();
        tick();
        run_dump("full", 100, 1'b0, 0, bc, gn);
        check("full busy cycles", bc, DUMP_CYCS);
        tick();
        check("resume regAddr", regAddr, 7);
        tick();
        check("resume dispData", dispData, regs[7]);

        run_dump("bp30", 30, 1'b0, 0, bc, gn);

        run_dump("pulses", 100, 1'b1, 0, bc, gn);
        check("pulses busy cycles", bc, DUMP_CYCS);
        for (int i = 0; i < 10; i++) begin
            check("no retrigger busy", busy, 0);
            check("no retrigger valid", outValid, 0);
            tick();
        end
        start = 1'b0;
        tick();

        for (int i = 0; i < N; i++) regs[i] = $urandom;
        manualAddr = 5'($urandom_range(0, N - 1));
        tick();
        tick();
        run_dump("rand", 50, 1'b0, 0, bc, gn);

        run_dump("abort", 40, 1'b0, 10, bc, gn);
        check("abort got bytes", gn, 10);
        check("abort busy before rst", busy, 1);
        rst_n = 1'b0;
        tick();
        check("abort valid", outValid, 0);
        check("abort busy", busy, 0);
        check("abort outData", outData, 0);
        check("abort regAddr", regAddr, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("abort idle", busy, 0);
        run_dump("fresh", 70, 1'b0, 0, bc, gn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
